// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Brief   : Two-requester round-robin arbiter with a bounded hold, sharing a
//           single-port 256x8 asynchronous-read RAM. Read data is returned
//           registered with a one-cycle valid strobe.
// Revision: 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_we,
  input  logic       b_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] b_addr,
  input  logic [7:0] a_wdata,
  input  logic [7:0] b_wdata,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic [7:0] a_rdata,
  output logic [7:0] b_rdata,
  output logic       a_rvalid,
  output logic       b_rvalid,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data_o,
  input  logic [7:0] ram_data_i,
  output logic       wr_en
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // Round-robin pointer encoding: which requester was granted most recently.
  localparam logic c_last_a = 1'b0;
  localparam logic c_last_b = 1'b1;

  localparam logic [CW:0] c_hold_max = (CW+1)'(MAX_HOLD);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [7:0]    a_rdata_q, b_rdata_q;
  logic          a_rvalid_q, b_rvalid_q;

  logic          xfer_a_w, xfer_b_w;
  logic [CW:0]   hold_inc_w;
  logic          limit_hit_w;
  logic [CW-1:0] hold_sat_w;

  assign a_gnt    = (state_q == GNT_A);
  assign b_gnt    = (state_q == GNT_B);
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

  assign xfer_a_w = a_gnt & a_req;
  assign xfer_b_w = b_gnt & b_req;

  // hold_inc_w is the transfer count including the one happening now; the
  // owner must yield once that reaches MAX_HOLD and the other side waits.
  assign hold_inc_w  = {1'b0, hold_q} + (CW+1)'(1);
  assign limit_hit_w = (hold_inc_w >= c_hold_max);
  assign hold_sat_w  = (hold_inc_w > c_hold_max) ? hold_q : hold_inc_w[CW-1:0];

  // Drive the RAM bus from the owner only while it is actually transferring.
  always_comb begin
    ram_addr   = 8'h00;
    ram_data_o = 8'h00;
    wr_en      = 1'b0;
    if (xfer_a_w) begin
      ram_addr   = a_addr;
      ram_data_o = a_wdata;
      wr_en      = a_we & ~rst;
    end else if (xfer_b_w) begin
      ram_addr   = b_addr;
      ram_data_o = b_wdata;
      wr_en      = b_we & ~rst;
    end
  end

  // Next-state, round-robin pointer and hold counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          if (last_q == c_last_b) begin
            state_d = GNT_A;
            last_d  = c_last_a;
          end else begin
            state_d = GNT_B;
            last_d  = c_last_b;
          end
          hold_d = '0;
        end else if (a_req) begin
          state_d = GNT_A;
          last_d  = c_last_a;
          hold_d  = '0;
        end else if (b_req) begin
          state_d = GNT_B;
          last_d  = c_last_b;
          hold_d  = '0;
        end
      end
      GNT_A: begin
        if (a_req && (!b_req || !limit_hit_w)) begin
          hold_d = hold_sat_w;
        end else if (b_req) begin
          state_d = GNT_B;
          last_d  = c_last_b;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      GNT_B: begin
        if (b_req && (!a_req || !limit_hit_w)) begin
          hold_d = hold_sat_w;
        end else if (a_req) begin
          state_d = GNT_A;
          last_d  = c_last_a;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= c_last_b;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Capture read data at the end of a read transfer and strobe valid once.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q  <= 8'h00;
      b_rdata_q  <= 8'h00;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= xfer_a_w & ~a_we;
      b_rvalid_q <= xfer_b_w & ~b_we;
      if (xfer_a_w && !a_we) begin
        a_rdata_q <= ram_data_i;
      end
      if (xfer_b_w && !b_we) begin
        b_rdata_q <= ram_data_i;
      end
    end
  end

endmodule
`default_nettype wire
